// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider: width default,
// FSM state encoding and the full-adder cell used by the subtractor chain.
package seq_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, dbz, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, dbz, quotient, remainder
    );

endinterface

// File: rtl/ripple_sub.sv
// N-bit ripple subtractor a - b built as a + ~b + 1 on a chain of full-adder
// cells; borrow is the inverted final carry.
module ripple_sub
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0]   carry;
    logic [N-1:0] b_inv;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign {carry[i+1], diff[i]} = full_add(a[i], b_inv[i], carry[i]);
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations,
// results and a one-cycle done pulse registered on entry to DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign trial_a = (WIDTH+1)'({r_q, q_q[WIDTH-1]});
    assign trial_b = {1'b0, d_q};

    ripple_sub #(.N(WIDTH + 1)) u_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    assign r_step = trial_borrow ? trial_a : trial_diff;
    assign q_step = {q_q[WIDTH-2:0], ~trial_borrow};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    r_d    = '0;
                    q_d    = bus.dividend;
                    d_d    = bus.divisor;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (bus.divisor == '0) begin
                        // Divide by zero short-circuits straight to DONE.
                        state_d = DONE;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                    end else begin
                        state_d = RUN;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quo_d   = q_step;
                    rem_d   = WIDTH'(r_step);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbz       = dbz_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider: results, latency, busy window,
// divide-by-zero, ignored starts and asynchronous reset mid-run.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one division and check result, latency, busy window and done width.
    task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        int lat;
        int busy_cyc;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = 1;
        busy_cyc = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy) busy_cyc++;
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":done"}, 32'(bus.done), 32'd1);
        chk({tag, ":quotient"}, bus.quotient, exp_q);
        chk({tag, ":remainder"}, bus.remainder, exp_r);
        chk({tag, ":dbz"}, 32'(bus.dbz), 32'(exp_dbz));
        chk({tag, ":busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
        @(negedge clk);
        chk({tag, ":done_width"}, 32'(bus.done), 32'd0);
        chk({tag, ":busy_fall"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [31:0] a;
        logic [31:0] b;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst:busy", 32'(bus.busy), 32'd0);
        chk("rst:done", 32'(bus.done), 32'd0);
        chk("rst:dbz", 32'(bus.dbz), 32'd0);
        chk("rst:quotient", bus.quotient, 32'd0);
        chk("rst:remainder", bus.remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
        run_div("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
        run_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // Second start during RUN must be ignored.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(negedge clk);
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            if (cyc == 10) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("ignore:latency", 32'(cyc), 32'd33);
        chk("ignore:quotient", bus.quotient, 32'd333);
        chk("ignore:remainder", bus.remainder, 32'd1);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("ignore:no_extra_done", 32'(pulses), 32'd0);

        // Asynchronous reset at cycle 20 of a run.
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:busy", 32'(bus.busy), 32'd0);
        chk("midrst:done", 32'(bus.done), 32'd0);
        chk("midrst:dbz", 32'(bus.dbz), 32'd0);
        chk("midrst:quotient", bus.quotient, 32'd0);
        chk("midrst:remainder", bus.remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        chk("midrst:no_done", 32'(pulses), 32'd0);
        run_div("postrst 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // Random operands, with divisor 0 and 1 forced periodically.
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if (i % 10 == 0)      b = 32'd0;
            else if (i % 10 == 1) b = 32'd1;
            else if (i % 3 == 0)  b = 32'($urandom_range(1, 255));
            else                  b = $urandom;
            if (b == 32'd0)
                run_div($sformatf("rnd%0d", i), a, b, 32'hFFFF_FFFF, a, 1'b1, 1);
            else
                run_div($sformatf("rnd%0d", i), a, b, a / b, a % b, 1'b0, 33);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
